// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports and the memory port of the arbiter.
//   Fetch port : if_req, if_addr -> if_rdata, if_ready
//   Data port  : d_req, d_we, d_wstrb, d_addr, d_wdata -> d_rdata, d_ready
//   Memory port: mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (read data one cycle after mem_en)
// The slave modport is the arbiter's view.
// The master modport is the environment's view: both requesters and the memory.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ready;

   logic              d_req;
   logic              d_we;
   logic [3:0]        d_wstrb;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic [31:0]       d_rdata;
   logic              d_ready;

   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory port between an instruction
// fetch requester and a load/store requester.
//
// Each access is issued combinationally in an IDLE cycle.
// It completes with a one-cycle ready pulse in the following WAIT cycle.
// Throughput is therefore one access every two cycles.
//
// Data accesses normally win arbitration.
// The streak counter counts data grants taken while a fetch was also waiting.
// Once the counter reaches MAX_DATA_STREAK, a waiting fetch is granted next.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset; all outputs are forced to 0 while it is high
//   bus   - mem_arbiter_if.slave (fetch port, data port, memory port)
module mem_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input logic         clk,
   input logic         reset,
   mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_WAIT = 2'd1,
      D_WAIT  = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [SW-1:0] streak_reg, streak_next;
   // Remembers whether the access in flight on the data port is a store.
   // A store completes with d_rdata = 0.
   logic          store_reg, store_next;

   logic grant_d;
   logic grant_i;

   // The low address bits select a byte inside the word and are not used by the word-addressed memory.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

   // Grant decisions only take effect in IDLE; they are qualified by state below.
   assign grant_d = bus.d_req && (!bus.if_req || (streak_reg < STREAK_MAX));
   assign grant_i = !grant_d && bus.if_req;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         streak_reg <= '0;
         store_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         streak_reg <= streak_next;
         store_reg  <= store_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next  = state_reg;
      streak_next = streak_reg;
      store_next  = store_reg;
      case (state_reg)
         IDLE: begin
            if (grant_d) begin
               state_next = D_WAIT;
               store_next = bus.d_we;
               if (!bus.if_req) begin
                  streak_next = '0;
               end else if (streak_reg != STREAK_MAX) begin
                  streak_next = streak_reg + 1'b1;
               end
            end else if (grant_i) begin
               state_next  = IF_WAIT;
               streak_next = '0;
            end
         end
         IF_WAIT: state_next = IDLE;
         D_WAIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 4'b0000;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.if_ready  = 1'b0;
      bus.if_rdata  = '0;
      bus.d_ready   = 1'b0;
      bus.d_rdata   = '0;
      // Reset silences every output, including a completion that would otherwise pulse in a WAIT cycle.
      if (!reset) begin
         case (state_reg)
            IDLE: begin
               if (grant_d) begin
                  bus.mem_en    = 1'b1;
                  bus.mem_addr  = bus.d_addr[ADDR_W-1:2];
                  bus.mem_wdata = bus.d_wdata;
                  bus.mem_we    = bus.d_we ? bus.d_wstrb : 4'b0000;
               end else if (grant_i) begin
                  bus.mem_en   = 1'b1;
                  bus.mem_addr = bus.if_addr[ADDR_W-1:2];
               end
            end
            IF_WAIT: begin
               bus.if_ready = 1'b1;
               bus.if_rdata = bus.mem_rdata;
            end
            D_WAIT: begin
               bus.d_ready = 1'b1;
               bus.d_rdata = store_reg ? 32'h0 : bus.mem_rdata;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter.
// A small synchronous-read memory model serves the arbiter's memory port.
// Expected values come from a transaction-level reference model and a shadow copy of the memory contents.
module tb_mem_arbiter;
   localparam int ADDR_W = 32;
   localparam int MAXS   = 4;

   typedef logic [132:0] snap_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_STREAK(MAXS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Memory model: synchronous read, byte-enabled write, 256 words.
   logic [31:0] mem_arr [0:255];
   logic [31:0] ref_mem [0:255];
   logic        init_mem;
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= 32'hC0DE_0000 | 32'(i);
         bus.mem_rdata <= 32'h0;
      end else if (pl_en) begin
         mem_arr[pl_addr] <= pl_data;
      end else if (bus.mem_en) begin
         bus.mem_rdata <= mem_arr[bus.mem_addr[7:0]];
         for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) mem_arr[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
   end

   function automatic snap_t outs();
      return {bus.if_ready, bus.if_rdata, bus.d_ready, bus.d_rdata,
              bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
   endfunction

   task automatic clear_inputs();
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_wstrb = 4'h0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; init_mem = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      clear_inputs();
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wstrb = 4'hF; bus.d_addr = 32'h80; bus.d_wdata = 32'h1234_5678;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         tests++;
         if (outs() !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", outs());
         end
      end
      @(negedge clk);
      init_mem = 1'b0;
      clear_inputs();
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      preload(8'h04, 32'h0000_0013);
   endtask

   task automatic test_fetch();
      @(negedge clk);
      reset = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
      #1;
      tests++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 4'b0000, 30'h4}) begin
         fails++;
         $display("FAIL fetch_issue: got en=%b we=%b addr=%h expected en=1 we=0 addr=4",
                  bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      @(negedge clk); #1;
      tests++;
      if ({bus.if_ready, bus.if_rdata, bus.d_ready, bus.mem_en} !== {1'b1, 32'h13, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL fetch_done: got if_ready=%b if_rdata=%h d_ready=%b mem_en=%b expected 1 00000013 0 0",
                  bus.if_ready, bus.if_rdata, bus.d_ready, bus.mem_en);
      end
      $display("[TB] fetch addr=00000010 rdata=%h", bus.if_rdata);
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_store();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wstrb = 4'b0011;
      bus.d_addr = 32'h0000_0102; bus.d_wdata = 32'hDEAD_BEEF;
      #1;
      tests++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'b0011, 30'h40, 32'hDEAD_BEEF}) begin
         fails++;
         $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h expected 1 0011 40 deadbeef",
                  bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      ref_mem[8'h40][15:0] = 16'hBEEF;
      @(negedge clk); #1;
      tests++;
      if ({bus.d_ready, bus.d_rdata, bus.mem_we, bus.mem_en, bus.if_ready} !== {1'b1, 32'h0, 4'h0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL store_done: got d_ready=%b d_rdata=%h mem_we=%b mem_en=%b if_ready=%b expected 1 0 0 0 0",
                  bus.d_ready, bus.d_rdata, bus.mem_we, bus.mem_en, bus.if_ready);
      end
      $display("[TB] store addr=00000102 wstrb=0011 wdata=deadbeef");
      // A load from the same word must return the merged bytes.
      @(negedge clk);
      bus.d_we = 1'b0; bus.d_addr = 32'h0000_0100;
      @(negedge clk); #1;
      tests++;
      if ({bus.d_ready, bus.d_rdata} !== {1'b1, ref_mem[8'h40]}) begin
         fails++;
         $display("FAIL store_readback: got d_ready=%b d_rdata=%h expected 1 %h", bus.d_ready, bus.d_rdata, ref_mem[8'h40]);
      end
      $display("[TB] load addr=00000100 rdata=%h", bus.d_rdata);
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_contention();
      logic [5:0] seq_is_fetch;
      logic       last_fetch;
      seq_is_fetch = 6'b010000; // grant k is a fetch when bit k is set: D,D,D,D,I,D
      last_fetch = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 32'h20;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8;
      for (int c = 0; c < 12; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         tests++;
         if (c % 2 == 0) begin
            last_fetch = seq_is_fetch[c/2];
            if ({bus.mem_en, bus.mem_addr, bus.if_ready, bus.d_ready} !== {1'b1, (last_fetch ? 30'h8 : 30'h2), 2'b00}) begin
               fails++;
               $display("FAIL contention_grant%0d: got en=%b addr=%h expected en=1 addr=%h", c/2,
                        bus.mem_en, bus.mem_addr, last_fetch ? 30'h8 : 30'h2);
            end
         end else begin
            if ({bus.mem_en, bus.if_ready, bus.d_ready} !== {1'b0, last_fetch, !last_fetch}) begin
               fails++;
               $display("FAIL contention_ready%0d: got en=%b if_ready=%b d_ready=%b expected 0 %b %b", c/2,
                        bus.mem_en, bus.if_ready, bus.d_ready, last_fetch, !last_fetch);
            end
            $display("[TB] contention grant %0d port=%s", c/2, last_fetch ? "I" : "D");
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
      #1;
      tests++;
      if (bus.mem_en !== 1'b1) begin
         fails++;
         $display("FAIL resetmid_issue: got mem_en=%b expected 1", bus.mem_en);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if (outs() !== '0) begin
         fails++;
         $display("FAIL resetmid_wait: got %h expected 0", outs());
      end
      @(negedge clk);
      reset = 1'b0;
      clear_inputs();
      for (int c = 0; c < 3; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         tests++;
         if (outs() !== '0) begin
            fails++;
            $display("FAIL resetmid_after%0d: got %h expected 0", c, outs());
         end
      end
      $display("[TB] load addr=00000010 abandoned by reset");
   endtask

   task automatic test_late_req();
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      #1;
      tests++;
      if ({bus.mem_en, bus.d_ready, bus.if_ready} !== 3'b010) begin
         fails++;
         $display("FAIL late_dwait: got en=%b d_ready=%b if_ready=%b expected 0 1 0", bus.mem_en, bus.d_ready, bus.if_ready);
      end
      @(negedge clk);
      bus.d_req = 1'b0;
      #1;
      tests++;
      if ({bus.mem_en, bus.mem_addr, bus.mem_we} !== {1'b1, 30'h10, 4'h0}) begin
         fails++;
         $display("FAIL late_issue: got en=%b addr=%h we=%b expected 1 10 0", bus.mem_en, bus.mem_addr, bus.mem_we);
      end
      @(negedge clk); #1;
      tests++;
      if ({bus.if_ready, bus.if_rdata} !== {1'b1, ref_mem[8'h10]}) begin
         fails++;
         $display("FAIL late_done: got if_ready=%b if_rdata=%h expected 1 %h", bus.if_ready, bus.if_rdata, ref_mem[8'h10]);
      end
      $display("[TB] late fetch addr=00000040 rdata=%h", bus.if_rdata);
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_idle();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         tests++;
         if ({bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready} !== 7'b0) begin
            fails++;
            $display("FAIL idle%0d: got en=%b we=%b if_ready=%b d_ready=%b expected all 0", c,
                     bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready);
         end
      end
   endtask

   // Random traffic against a transaction-level model.
   // The memory port is either serving one access or free.
   // A free port picks the data request unless a fetch has already been overtaken MAXS times in a row.
   task automatic test_random();
      logic        ip, dp, dwe, busy, busy_fetch;
      logic [31:0] iaddr, daddr, dwdata, exp_rd;
      logic [3:0]  dstrb;
      int          overtakes;
      logic [65:0] e_rsp;
      logic [66:0] e_mem;
      @(negedge clk);
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      reset = 1'b0;
      ip = 1'b0; dp = 1'b0; busy = 1'b0; busy_fetch = 1'b0; overtakes = 0;
      iaddr = '0; daddr = '0; dwdata = '0; dstrb = '0; dwe = 1'b0; exp_rd = '0;
      for (int c = 0; c < 400; c++) begin
         if (c != 0) @(negedge clk);
         if (!ip && $urandom_range(0, 2) != 0) begin
            ip = 1'b1;
            iaddr = {22'h0, 8'($urandom), 2'($urandom)};
         end
         if (!dp && $urandom_range(0, 3) != 0) begin
            dp = 1'b1;
            dwe = 1'($urandom);
            dstrb = 4'($urandom);
            daddr = {22'h0, 8'($urandom), 2'($urandom)};
            dwdata = $urandom;
         end
         bus.if_req = ip; bus.if_addr = iaddr;
         bus.d_req = dp; bus.d_we = dwe; bus.d_wstrb = dstrb; bus.d_addr = daddr; bus.d_wdata = dwdata;
         #1;
         e_rsp = '0;
         e_mem = '0;
         if (busy) begin
            if (busy_fetch) e_rsp = {1'b1, exp_rd, 1'b0, 32'h0};
            else            e_rsp = {1'b0, 32'h0, 1'b1, exp_rd};
         end else if (dp && (!ip || overtakes < MAXS)) begin
            e_mem = {1'b1, dwe ? dstrb : 4'h0, daddr[31:2], dwdata};
            overtakes = ip ? overtakes + 1 : 0;
            exp_rd = dwe ? 32'h0 : ref_mem[daddr[9:2]];
            if (dwe)
               for (int b = 0; b < 4; b++)
                  if (dstrb[b]) ref_mem[daddr[9:2]][b*8 +: 8] = dwdata[b*8 +: 8];
         end else if (ip) begin
            e_mem = {1'b1, 4'h0, iaddr[31:2], 32'h0};
            overtakes = 0;
            exp_rd = ref_mem[iaddr[9:2]];
         end
         tests++;
         if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== e_mem) begin
            fails++;
            $display("FAIL rand_mem cycle %0d: got %h expected %h", c,
                     {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, e_mem);
         end
         tests++;
         if ({bus.if_ready, bus.if_rdata, bus.d_ready, bus.d_rdata} !== e_rsp) begin
            fails++;
            $display("FAIL rand_rsp cycle %0d: got %h expected %h", c,
                     {bus.if_ready, bus.if_rdata, bus.d_ready, bus.d_rdata}, e_rsp);
         end
         if (busy) begin
            if (busy_fetch) begin
               $display("[TB] rand fetch addr=%h rdata=%h", iaddr, exp_rd);
               ip = 1'b0;
            end else begin
               $display("[TB] rand %s addr=%h rdata=%h", dwe ? "store" : "load", daddr, exp_rd);
               dp = 1'b0;
            end
            busy = 1'b0;
         end else if (e_mem[66]) begin
            busy = 1'b1;
            busy_fetch = (e_mem[65:62] == 4'h0) && (e_mem[61:32] == iaddr[31:2]) && ip &&
                         !(dp && (overtakes != 0 || !ip));
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_contention();
      test_reset_mid();
      test_late_req();
      test_idle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
